// File: rtl/pic_pkg.sv
// Shared constants and bus-mode decode for the PIC data buffer.
// DATA_BUFFER_SYNC_EN (in data_buffer / pic_edge_sync) adds a two-flop R/W synchronizer.
package pic_pkg;

  localparam int   DATA_WIDTH = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    BUS_IDLE     = 2'd0,
    BUS_READ     = 2'd1,
    BUS_WRITE    = 2'd2,
    BUS_CONFLICT = 2'd3
  } bus_mode_e;

  // Raw RD_n/WR_n decode; both low is the illegal case and drives nothing.
  function automatic bus_mode_e decode_mode(input logic r, input logic w);
    bus_mode_e m;
    case ({r, w})
      2'b01:   m = BUS_READ;
      2'b10:   m = BUS_WRITE;
      2'b00:   m = BUS_CONFLICT;
      default: m = BUS_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_buffer_if.sv
// CPU-side control and status bundle of the data buffer; mode/oe signals are debug taps.
// The master drives R/W/buffer, the slave (data_buffer) returns write data, strobes and flags.
interface data_buffer_if import pic_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
);
  // R and W are active-low enables with no handshake: a read or write phase lasts
  // as long as its enable stays low; strobes are single-cycle pulses marking the
  // start of a read and the end of a write.
  logic             R;
  logic             W;
  logic [WIDTH-1:0] buffer;
  logic [WIDTH-1:0] wdata;
  logic             wr_strobe;
  logic             rd_strobe;
  logic             conflict;
  bus_mode_e        mode;
  logic             d_oe;
  logic             internal_oe;

  modport master (
    output R, W, buffer,
    input  wdata, wr_strobe, rd_strobe, conflict, mode, d_oe, internal_oe
  );

  modport slave (
    input  R, W, buffer,
    output wdata, wr_strobe, rd_strobe, conflict, mode, d_oe, internal_oe
  );

endinterface

// File: rtl/pic_edge_sync.sv
// Per-strobe-input sampler: optional two-flop synchronizer (DATA_BUFFER_SYNC_EN)
// followed by a one-deep history register used for edge detection.
module pic_edge_sync import pic_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic prev
);

`ifdef DATA_BUFFER_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= IDLE_LEVEL;
      sync_2 <= IDLE_LEVEL;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  assign level = sync_2;
`else
  assign level = raw;
`endif

  // History resets to idle so the first edge after reset never looks like a transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= IDLE_LEVEL;
    else     prev <= level;
  end

endmodule

// File: rtl/data_buffer.sv
// 8259-style data bus buffer: steers D <-> InternalD from raw RD_n/WR_n and
// produces registered write data, read/write strobes and a conflict flag.
// Macro DATA_BUFFER_SYNC_EN inserts a 2-flop R/W synchronizer and matching D delay.
module data_buffer import pic_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] D,
  inout  wire  [WIDTH-1:0] InternalD,
  data_buffer_if.slave     bus
);

  bus_mode_e        mode;
  logic             d_oe;
  logic             internal_oe;
  logic             r_level;
  logic             r_prev;
  logic             w_level;
  logic             w_prev;
  logic [WIDTH-1:0] d_sample;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] wdata_q;
  logic             wr_strobe_q;
  logic             rd_strobe_q;
  logic             conflict_q;
  logic             wr_edge;
  logic             rd_edge;

  // Direction is purely combinational on the raw enables; reset and clk play no part.
  assign mode        = decode_mode(bus.R, bus.W);
  assign d_oe        = (mode == BUS_READ);
  assign internal_oe = (mode == BUS_WRITE);

  assign D         = d_oe        ? bus.buffer : {WIDTH{1'bz}};
  assign InternalD = internal_oe ? D          : {WIDTH{1'bz}};

  pic_edge_sync u_r_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.R),
    .level (r_level),
    .prev  (r_prev)
  );

  pic_edge_sync u_w_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.W),
    .level (w_level),
    .prev  (w_prev)
  );

`ifdef DATA_BUFFER_SYNC_EN
  logic [WIDTH-1:0] d_dly_1;
  logic [WIDTH-1:0] d_dly_2;

  // D travels through the same depth as R/W so the captured byte lines up with the write window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_dly_1 <= '0;
      d_dly_2 <= '0;
    end else begin
      d_dly_1 <= D;
      d_dly_2 <= d_dly_1;
    end
  end

  assign d_sample = d_dly_2;
`else
  assign d_sample = D;
`endif

  assign wr_edge = w_level & ~w_prev & r_level;
  assign rd_edge = ~r_level & r_prev & w_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      wdata_q     <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      if (~w_level & r_level) shadow <= d_sample;
      if (wr_edge)            wdata_q <= shadow;
      wr_strobe_q <= wr_edge;
      rd_strobe_q <= rd_edge;
      conflict_q  <= ~r_level & ~w_level;
    end
  end

  assign bus.wdata       = wdata_q;
  assign bus.wr_strobe   = wr_strobe_q;
  assign bus.rd_strobe   = rd_strobe_q;
  assign bus.conflict    = conflict_q;
  assign bus.mode        = mode;
  assign bus.d_oe        = d_oe;
  assign bus.internal_oe = internal_oe;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer; latency expectations follow DATA_BUFFER_SYNC_EN.
module tb_data_buffer;
  import pic_pkg::*;

`ifdef DATA_BUFFER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  wire  [7:0] D;
  wire  [7:0] internal_d;
  logic [7:0] tb_d;
  logic       tb_d_en;
  int         n_cmp;
  int         n_err;

  data_buffer_if #(.WIDTH(8)) bus ();

  assign D = tb_d_en ? tb_d : 8'bzzzzzzzz;

  data_buffer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .InternalD (internal_d),
    .bus       (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle 2 time units past the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_flags(input string tag, input logic wr, input logic rd, input logic cf);
    check({tag, ".wr_strobe"}, 16'(bus.wr_strobe), 16'(wr));
    check({tag, ".rd_strobe"}, 16'(bus.rd_strobe), 16'(rd));
    check({tag, ".conflict"},  16'(bus.conflict),  16'(cf));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.R     = 1'b1;
    bus.W     = 1'b1;
    bus.buffer = 8'h00;
    tb_d      = 8'h00;
    tb_d_en   = 1'b0;

    // Reset state
    #3;
    check("rst.wdata", 16'(bus.wdata), 16'h0000);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst.mode", 16'(bus.mode), 16'(BUS_IDLE));
    check("rst.d_oe", 16'(bus.d_oe), 16'h0);
    check("rst.int_oe", 16'(bus.internal_oe), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_flags("post_rst", 1'b0, 1'b0, 1'b0);
    end

    // Read: buffer presented on D, single rd_strobe after latency
    bus.buffer = 8'hAA;
    bus.R      = 1'b0;
    #1;
    check("rd.D", 16'(D), 16'h00AA);
    check("rd.d_oe", 16'(bus.d_oe), 16'h1);
    check("rd.int_oe", 16'(bus.internal_oe), 16'h0);
    check("rd.mode", 16'(bus.mode), 16'(BUS_READ));
    #1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_flags("rd", 1'b0, (k == LAT), 1'b0);
    end
    bus.R = 1'b1;
    #1;
    check("rd_end.d_oe", 16'(bus.d_oe), 16'h0);
    #1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_flags("rd_end", 1'b0, 1'b0, 1'b0);
    end

    // Write 5C held for 3 cycles
    tb_d    = 8'h5C;
    tb_d_en = 1'b1;
    bus.W   = 1'b0;
    #1;
    check("wr.InternalD", 16'(internal_d), 16'h005C);
    check("wr.int_oe", 16'(bus.internal_oe), 16'h1);
    check("wr.d_oe", 16'(bus.d_oe), 16'h0);
    #1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_flags("wr_hold", 1'b0, 1'b0, 1'b0);
      check("wr_hold.wdata", 16'(bus.wdata), 16'h0000);
    end
    bus.W   = 1'b1;
    tb_d_en = 1'b0;
    #1;
    check("wr_end.int_oe", 16'(bus.internal_oe), 16'h0);
    check("wr_end.d_oe", 16'(bus.d_oe), 16'h0);
    #1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_flags("wr_end", (k == LAT), 1'b0, 1'b0);
      check("wr_end.wdata", 16'(bus.wdata), (k >= LAT) ? 16'h005C : 16'h0000);
    end

    // Second write C3 for one cycle; wdata holds 5C until its strobe
    tb_d    = 8'hC3;
    tb_d_en = 1'b1;
    bus.W   = 1'b0;
    #1;
    check("wr2.InternalD", 16'(internal_d), 16'h00C3);
    #1;
    tick();
    check("wr2_hold.wdata", 16'(bus.wdata), 16'h005C);
    bus.W   = 1'b1;
    tb_d_en = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check("wr2.wr_strobe", 16'(bus.wr_strobe), 16'(k == LAT));
      check("wr2.wdata", 16'(bus.wdata), (k >= LAT) ? 16'h00C3 : 16'h005C);
    end

    // Idle: no strobes, wdata holds
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_flags("idle", 1'b0, 1'b0, 1'b0);
      check("idle.wdata", 16'(bus.wdata), 16'h00C3);
      check("idle.d_oe", 16'(bus.d_oe), 16'h0);
      check("idle.int_oe", 16'(bus.internal_oe), 16'h0);
    end

    // Conflict: both enables low
    bus.R = 1'b0;
    bus.W = 1'b0;
    #1;
    check("cf.d_oe", 16'(bus.d_oe), 16'h0);
    check("cf.int_oe", 16'(bus.internal_oe), 16'h0);
    check("cf.mode", 16'(bus.mode), 16'(BUS_CONFLICT));
    #1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_flags("cf", 1'b0, 1'b0, (k >= LAT));
      check("cf.wdata", 16'(bus.wdata), 16'h00C3);
    end
    bus.R = 1'b1;
    bus.W = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check("cf_exit.conflict", 16'(bus.conflict), 16'(k < LAT));
    end
    for (int k = 1; k <= 2; k++) tick();

    // Reset in the middle of a write of 33
    tb_d    = 8'h33;
    tb_d_en = 1'b1;
    bus.W   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstw.wdata", 16'(bus.wdata), 16'h0000);
    check_flags("rstw", 1'b0, 1'b0, 1'b0);
    check("rstw.InternalD", 16'(internal_d), 16'h0033);
    check("rstw.int_oe", 16'(bus.internal_oe), 16'h1);
    tick();
    bus.W   = 1'b1;
    tb_d_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      check_flags("rstw_rel", 1'b0, 1'b0, 1'b0);
      check("rstw_rel.wdata", 16'(bus.wdata), 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_buffer.md
DATA_BUFFER -- requirements
Module: data_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus width in bits.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port D  inout  WIDTH  external CPU data bus.
REQ-005 SHALL have port InternalD  inout  WIDTH  internal PIC data bus.
REQ-006 SHALL have port R  input  1  read enable, active-low (RD_n).
REQ-007 SHALL have port W  input  1  write enable, active-low (WR_n).
REQ-008 SHALL have port buffer  input  WIDTH  internal read data presented to CPU.
REQ-009 SHALL have port wdata  output  WIDTH  last captured write byte, registered.
REQ-010 SHALL have port wr_strobe  output  1  one-cycle pulse at end of write.
REQ-011 SHALL have port rd_strobe  output  1  one-cycle pulse at start of read.
REQ-012 SHALL have port conflict  output  1  registered flag, R and W both low.

Function
REQ-013 SHALL drive D with buffer combinationally when R=0 and W=1; D SHALL be high-Z otherwise.
REQ-014 SHALL drive InternalD with D combinationally when W=0 and R=1; InternalD SHALL be high-Z otherwise.
REQ-015 SHALL tri-state both D and InternalD when R=1 and W=1 (idle).
REQ-016 SHALL tri-state both buses when R=0 and W=0 (illegal), and SHALL set conflict=1 on the next clk edge; conflict SHALL clear on the first edge the condition is absent.
REQ-017 SHALL sample D into an internal shadow register on every clk edge where sampled W=0 and R=1.
REQ-018 SHALL copy the shadow register to wdata and pulse wr_strobe for exactly one cycle on the clk edge detecting a sampled W 0->1 transition with R=1.
REQ-019 SHALL pulse rd_strobe for exactly one cycle on the clk edge detecting a sampled R 1->0 transition with W=1.
REQ-020 SHALL suppress wr_strobe and rd_strobe on any edge where sampled R=0 and W=0; wdata SHALL then hold.
REQ-021 SHALL hold wdata unchanged between write strobes.
REQ-022 Bus direction (REQ-013..016) SHALL depend only on raw R/W, never on clk or sync stages.

Reset
REQ-023 SHALL on rst=1 immediately clear wdata, shadow register, wr_strobe, rd_strobe and conflict to 0.
REQ-024 SHALL on reset set R/W history and sync flops to 1 (idle) so no strobe fires on the first edge after release.
REQ-025 Reset SHALL NOT affect combinational bus drive; a write aborted by reset SHALL produce no wr_strobe.

Configuration
REQ-026 With macro DATA_BUFFER_SYNC_EN defined, R and W SHALL pass through a two-flop synchronizer before edge detection and sampling, adding 2 cycles to strobe/wdata/conflict latency; D SHALL be sampled through a matching 2-stage delay so wdata equals D held during the write.
REQ-027 Without DATA_BUFFER_SYNC_EN, R, W and D SHALL be sampled directly by one history register, strobe latency 1 cycle from the transition.

Structure
REQ-028 SHALL place WIDTH default and the idle level constant (1) in shared package pic_pkg.
REQ-029 SHALL implement the R/W synchronizer plus edge detector as sub-module pic_edge_sync, instantiated once per strobe input.

Verification
REQ-030 buffer=8'hAA, R=0, W=1 -> D=8'hAA, InternalD=Z, rd_strobe pulses once, conflict=0.
REQ-031 D driven 8'h5C, R=1, W=0 for 3 cycles then W=1 -> InternalD=8'h5C during write, then wdata=8'h5C and one wr_strobe pulse, D and InternalD Z.
REQ-032 R=1, W=1 -> D=Z, InternalD=Z, no strobes, wdata holds previous value.
REQ-033 R=0, W=0 -> D=Z, InternalD=Z, conflict=1 after latency, no strobes; return to R=1,W=1 -> conflict=0.
REQ-034 rst asserted mid-write (W=0, D=8'h33) then released with W=1 -> wdata=0, no wr_strobe, all flags 0.
REQ-035 Repeat REQ-031 with and without DATA_BUFFER_SYNC_EN -> wr_strobe at 3 vs 1 cycles after W rises.
